// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command-frame controller:
// FSM states, error codes, sync byte and baud-derived timing.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // 115200 baud from a 50 MHz clock; a frame may stall for ten bit times
    localparam int HALF_BIT_TICS        = 217;
    localparam int BIT_TICS             = 2 * HALF_BIT_TICS;
    localparam int DEFAULT_TIMEOUT_TICS = 10 * BIT_TICS;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                              input logic [7:0] data,
                                              input logic [7:0] sync);
        return addr ^ data ^ sync;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / register-write-out bundle of the command-frame controller.
// The master side feeds received bytes; the slave side is the controller.
interface uart_cmd_ctrl_if;
    import uart_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] err_cnt;
    err_e       last_err;

    modport master (
        output rx_byte, rx_valid,
        input  wr_en, wr_addr, wr_data, busy, err_cnt, last_err
    );

    modport slave (
        input  rx_byte, rx_valid,
        output wr_en, wr_addr, wr_data, busy, err_cnt, last_err
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: cleared by clr, counts while en, and pulses expire
// on the cycle the count sits at TIMEOUT_TICS-1 without a clear.
module uart_gap_timer #(
    parameter int TIMEOUT_TICS = 4340
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_TICS > 1) ? $clog2(TIMEOUT_TICS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expiry restarts the count so the next frame starts from zero
    always_comb begin
        expire = en && !clr && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses sync/addr/data/checksum frames from the serial receiver and turns
// each valid one into a single-cycle register write; bad frames are counted.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_TICS = DEFAULT_TIMEOUT_TICS,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic            clk50,
    input  logic            rst_n,
    uart_cmd_ctrl_if.slave  bus
);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    err_e       last_err_q, last_err_d;

    logic       expire;
    logic       drop;
    err_e       drop_code;

    uart_gap_timer #(
        .TIMEOUT_TICS (TIMEOUT_TICS)
    ) u_gap_timer (
        .clk50  (clk50),
        .rst_n  (rst_n),
        .clr    (bus.rx_valid),
        .en     (state_q != ST_IDLE),
        .expire (expire)
    );

    // A byte arriving on the expiry cycle wins because expire excludes rx_valid
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        drop       = 1'b0;
        drop_code  = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d  = bus.rx_byte;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    data_d  = bus.rx_byte;
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    state_d = ST_IDLE;
                    if (bus.rx_byte == frame_csum(addr_q, data_q, SYNC_BYTE)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                    end else begin
                        drop      = 1'b1;
                        drop_code = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (expire) begin
            state_d   = ST_IDLE;
            drop      = 1'b1;
            drop_code = ERR_TIMEOUT;
        end

        if (drop) begin
            last_err_d = drop_code;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_cnt_q  <= '0;
            last_err_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.err_cnt  = err_cnt_q;
    assign bus.last_err = last_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus random traffic, every cycle
// compared with a frame-level reference model built on a byte queue.
module tb_uart_cmd_ctrl;
    import uart_pkg::*;

    localparam int         T    = DEFAULT_TIMEOUT_TICS;
    localparam logic [7:0] SYNC = DEFAULT_SYNC_BYTE;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(
        .TIMEOUT_TICS (T),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk50 = ~clk50;

    int checkCount = 0;
    int errCount   = 0;

    // Reference model: bytes of the frame in progress and when the last one landed
    logic [7:0] frame[$];
    int         cyc;
    int         lastByteCyc;
    int         expWrEn, expAddr, expData, expBusy, expErrCnt, expLastErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        frame.delete();
        cyc         = 0;
        lastByteCyc = 0;
        expWrEn     = 0;
        expAddr     = 0;
        expData     = 0;
        expBusy     = 0;
        expErrCnt   = 0;
        expLastErr  = 0;
    endtask

    task automatic modelDrop(input int code);
        if (expErrCnt < 255) expErrCnt++;
        expLastErr = code;
        frame.delete();
    endtask

    // Advance the model by one clock edge with the given receiver input
    task automatic modelStep(input logic v, input logic [7:0] b);
        cyc++;
        expWrEn = 0;
        if (v) begin
            if (frame.size() != 0 || b == SYNC) begin
                frame.push_back(b);
                lastByteCyc = cyc;
            end
            if (frame.size() == 4) begin
                if (frame[3] == (frame[0] ^ frame[1] ^ frame[2])) begin
                    expWrEn = 1;
                    expAddr = frame[1];
                    expData = frame[2];
                    frame.delete();
                end else begin
                    modelDrop(1);
                end
            end
        end else if (frame.size() != 0 && (cyc - lastByteCyc) == T) begin
            modelDrop(2);
        end
        expBusy = (frame.size() != 0) ? 1 : 0;
    endtask

    task automatic checkAll();
        checkOutput("wr_en",    32'(bus.wr_en),    32'(expWrEn));
        checkOutput("wr_addr",  32'(bus.wr_addr),  32'(expAddr));
        checkOutput("wr_data",  32'(bus.wr_data),  32'(expData));
        checkOutput("busy",     32'(bus.busy),     32'(expBusy));
        checkOutput("err_cnt",  32'(bus.err_cnt),  32'(expErrCnt));
        checkOutput("last_err", 32'(bus.last_err), 32'(expLastErr));
    endtask

    // One clock: check what the previous edge produced, then drive the next input
    task automatic applyStimulus(input logic v, input logic [7:0] b);
        @(negedge clk50);
        checkAll();
        bus.rx_valid = v;
        bus.rx_byte  = v ? b : 8'($urandom);
        modelStep(v, b);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        idleCycles(gap);
        applyStimulus(1'b1, b);
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] c, input int gap);
        sendByte(SYNC, gap);
        sendByte(a, gap);
        sendByte(d, gap);
        sendByte(c, gap);
    endtask

    task automatic pulseReset();
        @(posedge clk50);
        #3;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        modelReset();
        #2;
        checkAll();
        @(negedge clk50);
        rst_n = 1'b1;
    endtask

    function automatic int randGap();
        if ($urandom_range(0, 39) == 0) return T - 2 + int'($urandom_range(0, 3));
        return int'($urandom_range(0, 30));
    endfunction

    initial begin
        logic [7:0] a, d, c;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        modelReset();
        repeat (3) @(negedge clk50);
        checkAll();
        rst_n = 1'b1;

        $display("[TB] valid frame, 434-cycle spacing");
        sendFrame(8'h10, 8'h3C, 8'h89, 433);
        idleCycles(3);

        $display("[TB] bad checksum then a good frame");
        sendFrame(8'h10, 8'h3C, 8'h00, 433);
        sendFrame(8'h10, 8'h3C, 8'h89, 433);
        idleCycles(3);

        $display("[TB] inter-byte timeout, late byte ignored");
        sendByte(SYNC, 433);
        sendByte(8'h10, 433);
        idleCycles(T);
        sendByte(8'h3C, 0);
        idleCycles(3);

        $display("[TB] leading noise");
        sendByte(8'h00, 5);
        sendByte(8'hFF, 5);
        sendFrame(8'h01, 8'h02, 8'hA6, 5);
        idleCycles(3);

        $display("[TB] byte on the exact expiry cycle, then one cycle late");
        sendByte(SYNC, 0);
        sendByte(8'h11, T - 1);
        sendByte(8'h22, T - 1);
        sendByte(SYNC ^ 8'h11 ^ 8'h22, T - 1);
        sendByte(SYNC, 0);
        sendByte(8'h11, T);
        idleCycles(3);

        $display("[TB] reset mid-frame after the data byte");
        sendByte(SYNC, 2);
        sendByte(8'h10, 2);
        sendByte(8'h3C, 2);
        pulseReset();
        sendByte(8'h89, 2);
        idleCycles(3);

        $display("[TB] 256 bad frames back to back");
        repeat (256) sendFrame(8'h01, 8'h02, 8'h00, 0);
        sendByte(SYNC, 0);
        sendByte(8'h01, 0);
        idleCycles(T + 2);
        sendFrame(8'h5A, 8'hC3, SYNC ^ 8'h5A ^ 8'hC3, 0);
        idleCycles(2);

        $display("[TB] random traffic");
        pulseReset();
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            c = SYNC ^ a ^ d;
            case ($urandom_range(0, 3))
                0: sendByte(8'($urandom), randGap());
                1: sendFrame(a, d, c ^ 8'($urandom_range(1, 255)), randGap());
                default: begin
                    sendByte(SYNC, randGap());
                    sendByte(a, randGap());
                    sendByte(d, randGap());
                    sendByte(c, randGap());
                end
            endcase
        end
        idleCycles(T + 2);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
